// File: rtl/pattern_sig_engine_pkg.sv
// Shared types and helpers for the pattern/signature engine: run states,
// default polynomials and the Galois step used by both the LFSR and the MISR.
package pse_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [31:0] LFSR_POLY_DEF = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEF = 32'h0000_0001;
  localparam logic [15:0] MISR_POLY_DEF = 16'hB400;

  // Wide enough for any stimulus or signature width; callers zero-extend in
  // and truncate out, which is exact for a right-shifting Galois register.
  localparam int GW = 64;

  function automatic logic [GW-1:0] galois_step(input logic [GW-1:0] value,
                                                input logic [GW-1:0] poly);
    return (value >> 1) ^ (value[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/sig_misr.sv
// Multiple-input signature register: compacts one response word per enabled
// cycle into a Galois-form signature. Clear has priority over enable.
module sig_misr
  import pse_pkg::*;
#(
  parameter int                 SIG_W     = 16,
  parameter int                 OUT_W     = 7,
  parameter logic [SIG_W-1:0]   MISR_POLY = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] din_ext;
  logic [SIG_W-1:0] sig_shift;

  assign din_ext   = SIG_W'(din);
  assign sig_shift = SIG_W'(galois_step(GW'(sig), GW'(MISR_POLY)));

  always_ff @(posedge clk) begin
    if (rst || clr) sig <= '0;
    else if (en)    sig <= sig_shift ^ din_ext;
  end

endmodule

// File: rtl/pattern_sig_engine.sv
// LFSR stimulus generator plus MISR response compactor wrapped around a
// combinational circuit under test; runs NUM_PAT patterns per start.
module pattern_sig_engine
  import pse_pkg::*;
#(
  parameter int                IN_W      = 32,
  parameter int                OUT_W     = 7,
  parameter int                SIG_W     = 16,
  parameter int                NUM_PAT   = 1024,
  parameter logic [IN_W-1:0]   LFSR_POLY = LFSR_POLY_DEF,
  parameter logic [IN_W-1:0]   LFSR_SEED = LFSR_SEED_DEF,
  parameter logic [SIG_W-1:0]  MISR_POLY = MISR_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  output logic [IN_W-1:0]  pi_vec,
  input  logic [OUT_W-1:0] po_vec,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

  localparam int              CNT_W = $clog2(NUM_PAT + 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [IN_W-1:0] SEED  = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             clr;
  logic             en;
  logic [IN_W-1:0]  pi_next;

  assign pi_next = IN_W'(galois_step(GW'(pi_vec), GW'(LFSR_POLY)));

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: if (start) begin state_d = RUN; clr = 1'b1; end
      RUN: begin
        en = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: if (start) begin state_d = RUN; clr = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pi_vec  <= SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        pi_vec <= SEED;
        cnt_q  <= '0;
      end else if (en) begin
        pi_vec <= pi_next;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  sig_misr #(
    .SIG_W     (SIG_W),
    .OUT_W     (OUT_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .din (po_vec),
    .sig (signature)
  );

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = done && (signature == golden);

endmodule

// File: tb/tb_pattern_sig_engine.sv
// Bench for pattern_sig_engine: several engine instances of different run
// lengths, checked against a pattern-by-pattern signature model.
module tb_pattern_sig_engine;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  function automatic logic [31:0] lfsr_nx(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [15:0] misr_nx(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
  endfunction

  // Stand-in netlist driven by the engine.
  function automatic logic [6:0] circ(input logic [31:0] p);
    return (p[6:0] + p[22:16]) ^ {7{^p}} ^ (p[31:25] & p[13:7]);
  endfunction

  // Signature after n patterns, each response xored with a fixed mask.
  function automatic logic [15:0] model_sig(input int n, input logic [6:0] mask);
    logic [31:0] p = 32'h1;
    logic [15:0] s = 16'h0;
    for (int k = 0; k < n; k++) begin
      s = misr_nx(s) ^ {9'h0, circ(p) ^ mask};
      p = lfsr_nx(p);
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // NUM_PAT=4 instance, driven by the model netlist
  logic start4; logic [15:0] gold4, sig4; logic [31:0] pi4; logic [6:0] po4;
  logic busy4, done4, pass4;
  assign po4 = circ(pi4);
  pattern_sig_engine #(.NUM_PAT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .golden(gold4), .pi_vec(pi4),
    .po_vec(po4), .busy(busy4), .done(done4), .signature(sig4), .pass(pass4));

  // NUM_PAT=2 instance, outputs tied to 7'h01
  logic start2; logic [15:0] gold2, sig2; logic [31:0] pi2; logic [6:0] po2;
  logic busy2, done2, pass2;
  assign po2 = 7'h01;
  pattern_sig_engine #(.NUM_PAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .golden(gold2), .pi_vec(pi2),
    .po_vec(po2), .busy(busy2), .done(done2), .signature(sig2), .pass(pass2));

  // NUM_PAT=8 instance with a random response mask per run
  logic start8; logic [15:0] gold8, sig8; logic [31:0] pi8; logic [6:0] po8, mask8;
  logic busy8, done8, pass8;
  assign po8 = circ(pi8) ^ mask8;
  pattern_sig_engine #(.NUM_PAT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .golden(gold8), .pi_vec(pi8),
    .po_vec(po8), .busy(busy8), .done(done8), .signature(sig8), .pass(pass8));

  // Equivalence pair, NUM_PAT=1024; copy b can have one output bit inverted
  logic start_eq, inj; logic [15:0] gold_a, sig_a, sig_b; logic [31:0] pi_a, pi_b;
  logic [6:0] po_a, po_b; logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  assign po_a = circ(pi_a);
  assign po_b = circ(pi_b) ^ (inj ? 7'h08 : 7'h00);
  pattern_sig_engine dut_a (
    .clk(clk), .rst(rst), .start(start_eq), .golden(gold_a), .pi_vec(pi_a),
    .po_vec(po_a), .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a));
  pattern_sig_engine dut_b (
    .clk(clk), .rst(rst), .start(start_eq), .golden(gold_a), .pi_vec(pi_b),
    .po_vec(po_b), .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b));

  typedef struct {
    logic [31:0] pi;
    logic        busy;
    logic        done;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   cyc;
    logic [15:0] exp8;

    rst = 1'b1; start4 = 0; start2 = 0; start8 = 0; start_eq = 0; inj = 0;
    gold4 = 16'h0; gold2 = 16'h0; gold8 = 16'h0; gold_a = 16'h0; mask8 = 7'h0;
    step(); step();
    check("rst_pi",   pi4,   32'h1);
    check("rst_sig",  sig4,  32'h0);
    check("rst_busy", busy4, 32'h0);
    check("rst_done", done4, 32'h0);
    check("rst_pass", pass4, 32'h0);
    rst = 1'b0;
    step();

    // LFSR sequence over a 4-pattern run
    tbl[0] = '{32'h0000_0001, 1'b1, 1'b0};
    tbl[1] = '{32'h8020_0003, 1'b1, 1'b0};
    tbl[2] = '{32'hC030_0002, 1'b1, 1'b0};
    tbl[3] = '{32'h6018_0001, 1'b1, 1'b0};
    tbl[4] = '{32'hB02C_0003, 1'b0, 1'b1};
    start4 = 1'b1; step(); start4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lfsr_pi[%0d]", i),   pi4,   tbl[i].pi);
      check($sformatf("lfsr_busy[%0d]", i), busy4, tbl[i].busy);
      check($sformatf("lfsr_done[%0d]", i), done4, tbl[i].done);
      if (i < 4) step();
    end
    check("sig4", sig4, model_sig(4, 7'h0));
    step();
    check("sig4_hold", sig4, model_sig(4, 7'h0));

    // MISR with constant response, pass against live golden
    gold2 = 16'hB401;
    start2 = 1'b1; step(); start2 = 1'b0;
    step();
    check("m2_done_early", done2, 32'h0);
    step();
    check("m2_done", done2, 32'h1);
    check("m2_sig",  sig2,  32'hB401);
    check("m2_pass", pass2, 32'h1);
    gold2 = 16'hB400; #1;
    check("m2_nopass", pass2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      gold2 = 16'($urandom); #1;
      check("m2_rand_pass", pass2, {31'h0, gold2 == 16'hB401});
    end
    // restart from DONE
    step();
    start2 = 1'b1; step(); start2 = 1'b0;
    check("m2_restart_done", done2, 32'h0);
    check("m2_restart_sig",  sig2,  32'h0);
    check("m2_restart_busy", busy2, 32'h1);
    step(); step();
    check("m2_rerun_sig", sig2, 32'hB401);

    // random start pulses during RUN must not change run length
    for (int r = 0; r < 3; r++) begin
      mask8 = 7'($urandom);
      start8 = 1'b1; step(); start8 = 1'b0;
      cyc = 1;
      while (!done8 && cyc < 50) begin
        start8 = 1'($urandom);
        step();
        cyc++;
      end
      start8 = 1'b0;
      check("hs_len", cyc, 32'd9);
      exp8 = model_sig(8, mask8);
      check("hs_sig", sig8, exp8);
      gold8 = exp8; #1;
      check("hs_pass", pass8, 32'h1);
      step();
    end

    // reset mid-run (with a simultaneous start), then a clean rerun
    mask8 = 7'($urandom);
    start8 = 1'b1; step(); start8 = 1'b0;
    step(); step();
    rst = 1'b1; start8 = 1'b1; step(); rst = 1'b0; start8 = 1'b0;
    check("mr_busy", busy8, 32'h0);
    check("mr_done", done8, 32'h0);
    check("mr_sig",  sig8,  32'h0);
    check("mr_pi",   pi8,   32'h1);
    step();
    check("mr_idle", busy8, 32'h0);
    start8 = 1'b1; step(); start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 50) begin step(); cyc++; end
    check("mr_len", cyc, 32'd9);
    check("mr_sig_full", sig8, model_sig(8, mask8));

    // equivalence: identical copies, then one inverted output bit
    gold_a = model_sig(1024, 7'h0);
    start_eq = 1'b1; step(); start_eq = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 1100) begin step(); cyc++; end
    check("eq_len",  cyc,   32'd1025);
    check("eq_sig_a", sig_a, model_sig(1024, 7'h0));
    check("eq_sig_b", sig_b, model_sig(1024, 7'h0));
    check("eq_pass", pass_a, 32'h1);
    inj = 1'b1;
    start_eq = 1'b1; step(); start_eq = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 1100) begin step(); cyc++; end
    check("inj_done", done_b, 32'h1);
    check("inj_sig_b", sig_b, model_sig(1024, 7'h08));
    check("inj_differ", {31'h0, sig_a != sig_b}, 32'h1);
    check("inj_nopass_b", pass_b, {31'h0, model_sig(1024, 7'h08) == gold_a});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
